// File: rtl/intr_pkg.sv
// Shared widths, helpers and stack-entry type for the interrupt controller.
package intr_pkg;

  // Widest return address and service level a stack entry can carry.
  localparam int unsigned PC_MAX_W  = 32;
  localparam int unsigned LVL_MAX_W = 8;

  function automatic int unsigned level_w(input int unsigned n_src);
    return $clog2(n_src + 1);
  endfunction

  function automatic int unsigned depth_w(input int unsigned nest);
    return $clog2(nest + 1);
  endfunction

  typedef struct packed {
    logic [PC_MAX_W-1:0]  pc;
    logic [LVL_MAX_W-1:0] level;
  } epc_entry_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-side bundle of the interrupt controller: requests, control strobes and redirect outputs.
interface intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned AW    = 32,
  parameter int unsigned NEST  = 4
);
  localparam int unsigned LW = level_w(N_SRC);
  localparam int unsigned DW = depth_w(NEST);

  logic [N_SRC-1:0] irq_in;
  logic             stall;
  logic [AW-1:0]    pc_next;
  logic             eret;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             gie_we;
  logic             gie_wdata;
  logic             take;
  logic [AW-1:0]    vector;
  logic [AW-1:0]    epc;
  logic [N_SRC-1:0] pending;
  logic [LW-1:0]    level;
  logic [DW-1:0]    depth;

  modport master (
    output irq_in, stall, pc_next, eret, mask_we, mask_wdata, gie_we, gie_wdata,
    input  take, vector, epc, pending, level, depth
  );

  modport slave (
    input  irq_in, stall, pc_next, eret, mask_we, mask_wdata, gie_we, gie_wdata,
    output take, vector, epc, pending, level, depth
  );

endinterface

// File: rtl/intr_epc_stack.sv
// LIFO of {return pc, interrupted level} with push, pop and replace-top.
module intr_epc_stack
  import intr_pkg::*;
#(
  parameter int unsigned NEST = 4,
  parameter int unsigned DW   = depth_w(NEST)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  epc_entry_t    din,
  output epc_entry_t    top,
  output logic [DW-1:0] depth
);

  epc_entry_t entries [NEST];

  // Push fills the slot above the top, replace overwrites the current top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NEST; i++) entries[i] <= '0;
      depth <= '0;
    end else begin
      for (int i = 0; i < NEST; i++) begin
        if ((push && depth == DW'(i)) || (replace && depth == DW'(i + 1)))
          entries[i] <= din;
      end
      if (push && depth != DW'(NEST))
        depth <= depth + DW'(1);
      else if (pop && depth != '0)
        depth <= depth - DW'(1);
    end
  end

  // Top-of-stack view; all zero when empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < NEST; i++) begin
      if (depth == DW'(i + 1)) top = entries[i];
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Nested, priority-based interrupt controller with an EPC return stack.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned      N_SRC      = 3,
  parameter int unsigned      AW         = 32,
  parameter int unsigned      NEST       = 4,
  parameter logic [AW-1:0]    VEC_BASE   = 32'h100,
  parameter logic [AW-1:0]    VEC_STRIDE = 32'h10,
  parameter logic [N_SRC-1:0] LEVEL_MASK = '0
) (
  input logic        clk,
  input logic        rst_n,
  intr_ctrl_if.slave bus
);

  localparam int unsigned LW = level_w(N_SRC);
  localparam int unsigned DW = depth_w(NEST);
  localparam int unsigned WW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]     irq_q;
  logic [N_SRC-1:0]     pending;
  logic [N_SRC-1:0]     mask;
  logic [N_SRC-1:0]     set_vec;
  logic [N_SRC-1:0]     clr_vec;
  logic                 gie;
  logic [LVL_MAX_W-1:0] level_r;
  logic [DW-1:0]        depth;
  logic                 full;
  logic                 take;
  logic                 tail;
  logic                 push;
  logic                 pop;
  logic [WW-1:0]        win;
  epc_entry_t           din;
  epc_entry_t           top;

  // Level sources request every cycle they are high, edge sources only on a rise.
  assign set_vec = bus.irq_in & (LEVEL_MASK | ~irq_q);
  assign full    = (depth == DW'(NEST));

  // Highest eligible index wins; inputs are registered state plus CPU inputs only.
  always_comb begin
    take = 1'b0;
    win  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pending[i] && !mask[i] && gie && !full && !bus.stall &&
          (LVL_MAX_W'(i + 1) > level_r)) begin
        take = 1'b1;
        win  = WW'(i);
      end
    end
  end

  // An eret meeting a take chains straight into the new handler without a pop.
  assign tail    = take && bus.eret && (depth != '0);
  assign push    = take && !tail;
  assign pop     = bus.eret && !take && (depth != '0);
  assign clr_vec = take ? (N_SRC'(1) << win) : '0;

  // Entry written on push or tail-chain; chaining keeps the level it replaces.
  always_comb begin
    din              = '0;
    din.pc[AW-1:0]   = bus.pc_next;
    din.level        = tail ? top.level : level_r;
  end

  // Request capture, mask/enable registers and current service level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b1;
      level_r <= '0;
    end else begin
      irq_q   <= bus.irq_in;
      pending <= (pending & ~clr_vec) | set_vec;
      if (bus.mask_we) mask <= bus.mask_wdata;
      if (bus.gie_we)  gie  <= bus.gie_wdata;
      if (take)
        level_r <= LVL_MAX_W'(win) + LVL_MAX_W'(1);
      else if (pop)
        level_r <= top.level;
    end
  end

  intr_epc_stack #(
    .NEST (NEST),
    .DW   (DW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .replace (tail),
    .din     (din),
    .top     (top),
    .depth   (depth)
  );

  assign bus.take    = take;
  assign bus.vector  = take ? (VEC_BASE + AW'(win) * VEC_STRIDE) : '0;
  assign bus.epc     = top.pc[AW-1:0];
  assign bus.pending = pending;
  assign bus.level   = level_r[LW-1:0];
  assign bus.depth   = depth;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: N_SRC=3, NEST=2, source 1 level-sensitive.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  intr_ctrl_if #(.N_SRC(3), .AW(32), .NEST(2)) bus ();

  intr_ctrl #(
    .N_SRC      (3),
    .AW         (32),
    .NEST       (2),
    .VEC_BASE   (32'h100),
    .VEC_STRIDE (32'h10),
    .LEVEL_MASK (3'b010)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        take;
    logic [31:0] vector;
    logic [31:0] epc;
    logic [2:0]  pending;
    logic [1:0]  level;
    logic [1:0]  depth;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected outputs for this cycle, then pop and compare once settled.
  task automatic ex(input string tag, input logic t, input logic [31:0] v,
                    input logic [31:0] e, input logic [2:0] p,
                    input logic [1:0] l, input logic [1:0] d);
    exp_t x;
    x.tag = tag; x.take = t; x.vector = v; x.epc = e;
    x.pending = p; x.level = l; x.depth = d;
    sb.push_back(x);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      x = sb.pop_front();
      cmp({x.tag, ".take"},    32'(bus.take),    32'(x.take));
      cmp({x.tag, ".vector"},  bus.vector,       x.vector);
      cmp({x.tag, ".epc"},     bus.epc,          x.epc);
      cmp({x.tag, ".pending"}, 32'(bus.pending), 32'(x.pending));
      cmp({x.tag, ".level"},   32'(bus.level),   32'(x.level));
      cmp({x.tag, ".depth"},   32'(bus.depth),   32'(x.depth));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.irq_in = '0; bus.stall = 1'b0; bus.pc_next = '0; bus.eret = 1'b0;
    bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.gie_we = 1'b0; bus.gie_wdata = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ex("reset", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // single edge request
    bus.irq_in = 3'b001; bus.pc_next = 32'h40;
    tick(); bus.irq_in = '0;
    ex("edge_take", 1'b1, 32'h100, 32'h0, 3'b001, 2'd0, 2'd0);
    tick();
    ex("edge_entered", 1'b0, 32'h0, 32'h40, 3'b000, 2'd1, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("edge_return", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // simultaneous requests: priority order
    bus.irq_in = 3'b101;
    tick(); bus.irq_in = '0; bus.pc_next = 32'h80;
    ex("prio_high_first", 1'b1, 32'h120, 32'h0, 3'b101, 2'd0, 2'd0);
    tick();
    ex("prio_high_in", 1'b0, 32'h0, 32'h80, 3'b001, 2'd3, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0; bus.pc_next = 32'h90;
    ex("prio_low_next", 1'b1, 32'h100, 32'h0, 3'b001, 2'd0, 2'd0);
    tick();
    ex("prio_low_in", 1'b0, 32'h0, 32'h90, 3'b000, 2'd1, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("prio_idle", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // nesting up to full stack
    bus.irq_in = 3'b001; bus.pc_next = 32'h200;
    tick(); bus.irq_in = '0;
    ex("nest_take0", 1'b1, 32'h100, 32'h0, 3'b001, 2'd0, 2'd0);
    tick();
    ex("nest_in0", 1'b0, 32'h0, 32'h200, 3'b000, 2'd1, 2'd1);
    bus.irq_in = 3'b010; bus.pc_next = 32'h204;
    tick(); bus.irq_in = '0;
    ex("nest_preempt", 1'b1, 32'h110, 32'h200, 3'b010, 2'd1, 2'd1);
    tick();
    ex("nest_in1", 1'b0, 32'h0, 32'h204, 3'b000, 2'd2, 2'd2);
    bus.irq_in = 3'b100;
    tick(); bus.irq_in = '0;
    ex("nest_full_block", 1'b0, 32'h0, 32'h204, 3'b100, 2'd2, 2'd2);
    tick();
    ex("nest_full_hold", 1'b0, 32'h0, 32'h204, 3'b100, 2'd2, 2'd2);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("nest_after_pop", 1'b1, 32'h120, 32'h200, 3'b100, 2'd1, 2'd1);
    tick();
    ex("nest_in2", 1'b0, 32'h0, 32'h204, 3'b000, 2'd3, 2'd2);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    ex("reset_mid_service", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // mask
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b100;
    tick(); bus.mask_we = 1'b0;
    bus.irq_in = 3'b100;
    tick(); bus.irq_in = '0;
    ex("mask_hold", 1'b0, 32'h0, 32'h0, 3'b100, 2'd0, 2'd0);
    bus.mask_we = 1'b1; bus.mask_wdata = 3'b000; bus.pc_next = 32'h300;
    ex("unmask_same_cycle", 1'b0, 32'h0, 32'h0, 3'b100, 2'd0, 2'd0);
    tick(); bus.mask_wdata = 3'b100;
    ex("unmask_take", 1'b1, 32'h120, 32'h0, 3'b100, 2'd0, 2'd0);
    tick(); bus.mask_we = 1'b0;
    ex("mask_during_take", 1'b0, 32'h0, 32'h300, 3'b000, 2'd3, 2'd1);
    bus.eret = 1'b1; bus.mask_we = 1'b1; bus.mask_wdata = 3'b000;
    tick(); bus.eret = 1'b0; bus.mask_we = 1'b0;
    ex("mask_idle", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // global enable
    bus.gie_we = 1'b1; bus.gie_wdata = 1'b0;
    tick(); bus.gie_we = 1'b0;
    bus.irq_in = 3'b011;
    tick();
    ex("gie_off_block", 1'b0, 32'h0, 32'h0, 3'b011, 2'd0, 2'd0);
    tick();
    ex("gie_off_hold", 1'b0, 32'h0, 32'h0, 3'b011, 2'd0, 2'd0);
    bus.irq_in = '0; bus.gie_we = 1'b1; bus.gie_wdata = 1'b1; bus.pc_next = 32'h400;
    ex("gie_on_same_cycle", 1'b0, 32'h0, 32'h0, 3'b011, 2'd0, 2'd0);
    tick(); bus.gie_we = 1'b0;
    ex("gie_on_take", 1'b1, 32'h110, 32'h0, 3'b011, 2'd0, 2'd0);
    tick();
    ex("gie_in1", 1'b0, 32'h0, 32'h400, 3'b001, 2'd2, 2'd1);
    bus.eret = 1'b1; bus.pc_next = 32'h500;
    tick(); bus.eret = 1'b0;
    ex("gie_low_after_ret", 1'b1, 32'h100, 32'h0, 3'b001, 2'd0, 2'd0);
    tick();
    ex("tc_in0", 1'b0, 32'h0, 32'h500, 3'b000, 2'd1, 2'd1);

    // tail-chain
    bus.irq_in = 3'b010;
    tick(); bus.irq_in = '0; bus.eret = 1'b1;
    ex("tail_take", 1'b1, 32'h110, 32'h500, 3'b010, 2'd1, 2'd1);
    tick(); bus.eret = 1'b0;
    ex("tail_chained", 1'b0, 32'h0, 32'h500, 3'b000, 2'd2, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("tail_return", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // eret with empty stack
    bus.eret = 1'b1;
    ex("eret_empty_cycle", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);
    tick(); bus.eret = 1'b0;
    ex("eret_empty_after", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // stall
    bus.stall = 1'b1; bus.irq_in = 3'b100; bus.pc_next = 32'h600;
    tick(); bus.irq_in = '0;
    ex("stall_block", 1'b0, 32'h0, 32'h0, 3'b100, 2'd0, 2'd0);
    tick();
    ex("stall_hold", 1'b0, 32'h0, 32'h0, 3'b100, 2'd0, 2'd0);
    bus.stall = 1'b0;
    ex("stall_release", 1'b1, 32'h120, 32'h0, 3'b100, 2'd0, 2'd0);
    tick();
    ex("stall_in2", 1'b0, 32'h0, 32'h600, 3'b000, 2'd3, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("stall_idle", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    // level-sensitive source held across return
    bus.irq_in = 3'b010; bus.pc_next = 32'h700;
    tick();
    ex("lvl_take", 1'b1, 32'h110, 32'h0, 3'b010, 2'd0, 2'd0);
    tick();
    ex("lvl_in", 1'b0, 32'h0, 32'h700, 3'b010, 2'd2, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("lvl_retake", 1'b1, 32'h110, 32'h0, 3'b010, 2'd0, 2'd0);
    bus.irq_in = '0;
    tick();
    ex("lvl_in_again", 1'b0, 32'h0, 32'h700, 3'b000, 2'd2, 2'd1);
    bus.eret = 1'b1;
    tick(); bus.eret = 1'b0;
    ex("lvl_idle", 1'b0, 32'h0, 32'h0, 3'b000, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_SRC, 3, number of interrupt sources; highest index = highest priority.
- AW, 32, PC/vector width.
- NEST, 4, EPC stack depth, i.e. maximum nesting.
- VEC_BASE, 32'h100, vector of source 0.
- VEC_STRIDE, 32'h10, vector spacing; source i vectors to VEC_BASE + i*VEC_STRIDE.
- LEVEL_MASK, 0, per-source bit: 1 = level-sensitive, 0 = rising-edge.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge.
- rst_n, in, 1, synchronous, active-low reset.
- irq_in, in, N_SRC, raw interrupt requests, already synchronous to clk.
- stall, in, 1, CPU halted; blocks take.
- pc_next, in, AW, return address pushed on take.
- eret, in, 1, exception-return instruction in this cycle.
- mask_we, in, 1, mask write strobe.
- mask_wdata, in, N_SRC, new mask; 1 = source masked.
- gie_we, in, 1, global-enable write strobe.
- gie_wdata, in, 1, new global-enable value.
- take, out, 1, combinational; redirect PC to vector this cycle.
- vector, out, AW, entry address of the winning source; 0 when take = 0.
- epc, out, AW, top-of-stack return address; 0 when the stack is empty.
- pending, out, N_SRC, pending register.
- level, out, clog2(N_SRC+1), 0 = idle; i+1 = source i in service.
- depth, out, clog2(NEST+1), stack occupancy.

Function
REQ-003 Edge source i SHALL set pending[i] at the posedge where irq_in[i]=1 and irq_q[i]=0, with irq_q being irq_in registered; level source i SHALL set pending[i] at every posedge where irq_in[i]=1.
REQ-004 Source i SHALL be eligible when pending[i] & ~mask[i] & gie & (i+1 > level) & (depth < NEST) & ~stall all hold.
REQ-005 take SHALL be 1 whenever any source is eligible; the winner is the highest eligible index, and vector = VEC_BASE + winner*VEC_STRIDE.
REQ-006 On a posedge with take=1 the block SHALL:
- push {pc_next, level};
- set level to winner+1;
- increment depth;
- clear pending[winner].
A set on that same edge SHALL override the clear, so a request re-asserted in that cycle is not lost.
REQ-007 On a posedge with eret=1, take=0 and depth>0, the block SHALL pop the stack, restore level from the popped entry and decrement depth.
REQ-008 eret with depth=0 SHALL be ignored, with no state change.
REQ-009 When eret=1 and take=1 in the same cycle, the stack top SHALL be replaced by {pc_next, popped level}, depth SHALL be unchanged and level SHALL become winner+1 (tail-chaining).
REQ-010 A higher-priority source SHALL preempt an in-service lower one (nesting); equal or lower priority SHALL wait until eret lowers level.
REQ-011 With depth=NEST, take SHALL stay 0 and pending SHALL be retained.
REQ-012 mask and gie writes SHALL take effect from the cycle after the strobe; a write coinciding with take SHALL NOT affect that take.
REQ-013 The take path SHALL never clear gie; software clears gie explicitly.

Reset
REQ-014 At a posedge with rst_n=0 the block SHALL set:
- pending = 0
- irq_q = 0
- mask = 0
- gie = 1
- level = 0
- depth = 0
- all stack entries = 0
REQ-015 The resulting outputs after reset SHALL be take=0, vector=0 and epc=0.
REQ-016 Reset asserted mid-service SHALL discard all nesting state; pending requests are lost.

Structure
REQ-017 Package intr_pkg SHALL hold:
- the level and depth width functions;
- the stack-entry struct {pc, level}.
REQ-018 The EPC LIFO SHALL be a sub-module intr_epc_stack with push, pop and replace operations and NEST entries.
REQ-019 The block SHALL contain no combinational loop from take back to eligibility.

Verification (N_SRC=3, NEST=2, VEC_BASE=0x100, VEC_STRIDE=0x10)
REQ-020 Single edge: pulse irq_in[0] with pc_next=0x40 -> take the next cycle with vector=0x100; then epc=0x40, level=1, pending=0.
REQ-021 Priority and nesting: irq 0 and 2 in the same cycle -> vector=0x120 first; after eret, vector=0x100; depth never exceeds 1. Separately, irq0 serviced then irq2 -> preemption, depth=2, a third source blocked.
REQ-022 Mask and gie: mask=3'b100 and irq2 -> no take, pending[2]=1; unmask -> take one cycle later. With gie=0, irqs held -> take=0.
REQ-023 Tail-chain: eret coincides with pending irq1 -> take=1, depth unchanged, epc unchanged, level=2.
REQ-024 Boundaries: eret at depth 0 -> no change; stall=1 with pending -> take=0 until stall drops; rst_n low at depth 2 -> depth=0, epc=0 on the next cycle.
REQ-025 Level source: LEVEL_MASK=3'b010 with irq1 held high across eret -> re-taken immediately after return.
